// File: rtl/switch_mcu_wb_arbiter_if.sv
// Writeback request bus plus regfile write port of the writeback arbiter.
// The master side is the requesters/regfile; the slave side is the arbiter.
interface switch_mcu_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    in_req_valid;
  logic [NUM_REQ*5-1:0]  in_req_waddr;
  logic [NUM_REQ*32-1:0] in_req_wdata;
  logic [NUM_REQ-1:0]    out_req_ready;
  logic                  in_rf_stall;
  logic                  in_flush;
  logic                  out_rf_wen;
  logic [4:0]            out_rf_waddr;
  logic [31:0]           out_rf_wdata;
  logic                  out_busy;

  modport master (
    output in_req_valid, in_req_waddr, in_req_wdata, in_rf_stall, in_flush,
    input  out_req_ready, out_rf_wen, out_rf_waddr, out_rf_wdata, out_busy
  );

  modport slave (
    input  in_req_valid, in_req_waddr, in_req_wdata, in_rf_stall, in_flush,
    output out_req_ready, out_rf_wen, out_rf_waddr, out_rf_wdata, out_busy
  );
endinterface

// File: rtl/switch_mcu_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between NUM_REQ writeback
// sources. Accepted writes go through a DEPTH-entry FIFO and drain one per cycle
// into registered regfile outputs. Writes to x0 are accepted and dropped.
module switch_mcu_wb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 2
) (
  input logic                    in_clk,
  input logic                    in_rst,
  switch_mcu_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] prio_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic [4:0]    mem_waddr_q [DEPTH];
  logic [31:0]   mem_wdata_q [DEPTH];
  logic          rf_wen_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] prio_next;
  logic          can_accept, accept, push, bypass, fifo_push, fifo_pop;
  logic [4:0]    sel_waddr;
  logic [31:0]   sel_wdata;

  // Scan valid bits from the priority pointer upward, wrapping; first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && bus.in_req_valid[(32'(prio_q) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((32'(prio_q) + k) % NUM_REQ);
      end
    end
  end

  // Grant decode, accept/push/pop decisions and the selected write payload.
  always_comb begin
    // Ready is held low in reset so all outputs read zero while in_rst is low.
    can_accept = in_rst && !bus.in_flush && (count_q < (PW+1)'(DEPTH));
    accept     = grant_valid && can_accept;
    bus.out_req_ready = '0;
    if (accept) bus.out_req_ready[grant_idx] = 1'b1;
    sel_waddr = bus.in_req_waddr[32'(grant_idx)*5 +: 5];
    sel_wdata = bus.in_req_wdata[32'(grant_idx)*32 +: 32];
    push      = accept && (sel_waddr != 5'd0);
    // With an empty FIFO the new write goes straight to the output register.
    bypass    = push && !bus.in_rf_stall && (count_q == '0);
    fifo_push = push && !bypass;
    fifo_pop  = !bus.in_rf_stall && (count_q != '0);
    prio_next = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // FIFO storage; no reset needed since count/pointers qualify every read.
  always_ff @(posedge in_clk) begin
    if (fifo_push) begin
      mem_waddr_q[wptr_q] <= sel_waddr;
      mem_wdata_q[wptr_q] <= sel_wdata;
    end
  end

  // Pointers, occupancy, round-robin priority and registered regfile write.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      prio_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (bus.in_flush) begin
      prio_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (accept)    prio_q <= prio_next;
      if (fifo_push) wptr_q <= wptr_q + 1'b1;
      if (fifo_pop)  rptr_q <= rptr_q + 1'b1;
      if (fifo_push && !fifo_pop)      count_q <= count_q + 1'b1;
      else if (!fifo_push && fifo_pop) count_q <= count_q - 1'b1;
      if (fifo_pop) begin
        rf_wen_q   <= 1'b1;
        rf_waddr_q <= mem_waddr_q[rptr_q];
        rf_wdata_q <= mem_wdata_q[rptr_q];
      end else if (bypass) begin
        rf_wen_q   <= 1'b1;
        rf_waddr_q <= sel_waddr;
        rf_wdata_q <= sel_wdata;
      end else begin
        rf_wen_q   <= 1'b0;
        rf_waddr_q <= '0;
        rf_wdata_q <= '0;
      end
    end
  end

  assign bus.out_rf_wen   = rf_wen_q;
  assign bus.out_rf_waddr = rf_waddr_q;
  assign bus.out_rf_wdata = rf_wdata_q;
  assign bus.out_busy     = (count_q != '0) || rf_wen_q;
endmodule

// File: doc/switch_mcu_wb_arbiter.md
Name: switch_mcu_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources (lui, auipc, arith, load units, etc.) using round-robin arbitration.
- Accepted writebacks are buffered in a DEPTH-entry FIFO and drained one per cycle onto the regfile port.
- Writes to x0 are discarded. The FIFO pauses while the regfile signals a stall and is cleared on pipeline flush.
- Sits between the ALU unit outputs and the register file write port.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- DEPTH, 2, buffer FIFO entries (power of 2, >=2).

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  asynchronous, active-low reset.
- in_req_valid  input  NUM_REQ  per-requester writeback request; bit i = requester i.
- in_req_waddr  input  NUM_REQ*5  packed dest register; slice [5i+4:5i] = requester i.
- in_req_wdata  input  NUM_REQ*32  packed write data; slice [32i+31:32i] = requester i.
- out_req_ready  output  NUM_REQ  one-hot (or zero) grant; transfer occurs when valid[i] & ready[i].
- in_rf_stall  input  1  regfile cannot accept a write this cycle.
- in_flush  input  1  discard all buffered writebacks.
- out_rf_wen  output  1  regfile write enable (registered).
- out_rf_waddr  output  5  regfile write address (registered).
- out_rf_wdata  output  32  regfile write data (registered).
- out_busy  output  1  FIFO non-empty or out_rf_wen high (combinational).

Behaviour:
- Reset (in_rst=0, async):
  - FIFO count, read and write pointers = 0.
  - Round-robin priority pointer = 0.
  - out_rf_wen = 0, out_rf_waddr = 0, out_rf_wdata = 0.
- Arbitration (combinational):
  - Search valid bits starting at the priority pointer, ascending, wrapping modulo NUM_REQ.
  - The first set bit i wins.
  - out_req_ready = onehot(i) only if count < DEPTH and in_flush = 0; otherwise all zero.
  - Ready may depend combinationally on valid. Requesters must hold valid, waddr and wdata stable until accepted.
- Pointer update: on an accepted transfer from requester i, priority pointer <= (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Accept:
  - On valid & ready with waddr != 0, push {waddr, wdata} to the FIFO tail.
  - With waddr == 0, the transfer completes (ready still high) but nothing is pushed. The pointer still advances.
- Drain (every cycle):
  - If in_rf_stall = 0 and count != 0: pop head and register out_rf_wen = 1, out_rf_waddr = head.waddr, out_rf_wdata = head.wdata.
  - Otherwise: out_rf_wen = 0, out_rf_waddr = 0, out_rf_wdata = 0.
- Latency: an accept in cycle N with an empty FIFO and no stall gives out_rf_wen high in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged. This is allowed when count = DEPTH-1 or less. No push is possible at count = DEPTH, because ready is low.
- Full with pop in the same cycle: ready stays low that cycle (no pass-through). Accepting resumes the next cycle.
- Stall: the head is held and order is preserved. A write is never lost or duplicated across any stall length.
- Flush:
  - At the next edge, count, read and write pointers are set to 0. out_rf_wen, out_rf_waddr and out_rf_wdata are set to 0, even if a pop was pending.
  - No accept occurs during the flush cycle. The priority pointer is reset to 0.
- Ordering: FIFO order equals accept order. The same waddr from different requesters is written in accept order; the last one wins in the regfile.
- Pointer wrap: FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset mid-operation: all buffered entries are discarded immediately. Outputs go to reset values asynchronously.

Test Plan:
- Single write: req1 valid, waddr=5, wdata=0x12345000 at cycle N -> ready[1]=1 at N; out_rf_wen=1, waddr=5, wdata=0x12345000 at N+1; out_busy low at N+2.
- Round-robin fairness: all 4 valid continuously, distinct waddr 1..4, no stall -> grants in order 0,1,2,3,0,…; regfile writes in the same order, one per cycle.
- Stall/full: in_rf_stall=1 with req0 and req2 valid -> 2 accepts, then ready=0. Release stall -> writes req0 then req2 on consecutive cycles, then req accepts resume.
- x0 drop: req3 writes waddr=0 with data 0xDEADBEEF -> ready[3]=1, pointer advances, out_rf_wen never asserted for it.
- Flush: FIFO holding 2 entries under stall, assert in_flush one cycle -> next cycle count=0, out_rf_wen=0, out_busy=0, no accept in the flush cycle, subsequent grant starts at requester 0.
- Async reset with FIFO full and output active -> all outputs 0 immediately; after release, the first grant goes to requester 0.
